// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package slice: multiply/divide op encoding, default latencies and result payload.
package mult_div_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MDU_CNT_W       = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_result_t;

endpackage

// File: rtl/mult_div_unit_compute.sv
// Combinational product / quotient / remainder, selected by op, signed or unsigned.
module mdu_compute
    import mult_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  mdu_op_e         op_i,
    output mdu_result_t     res_c
);

    localparam int unsigned PW = 2 * XLEN;

    logic            is_signed;
    logic            is_div;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   prod;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);

    // Sign/zero extension to 64 bits makes one unsigned multiply serve both forms.
    assign a_ext = is_signed ? {{XLEN{a_i[XLEN-1]}}, a_i} : {XLEN'(0), a_i};
    assign b_ext = is_signed ? {{XLEN{b_i[XLEN-1]}}, b_i} : {XLEN'(0), b_i};
    assign prod  = a_ext * b_ext;

    // Magnitude divide then re-sign: truncates toward zero and keeps MIN/-1 trap-free.
    assign a_neg = is_signed & a_i[XLEN-1];
    assign b_neg = is_signed & b_i[XLEN-1];
    assign a_mag = a_neg ? (XLEN'(0) - a_i) : a_i;
    assign b_mag = b_neg ? (XLEN'(0) - b_i) : b_i;

    always_comb begin
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
    end

    assign quot = (a_neg ^ b_neg) ? (XLEN'(0) - q_mag) : q_mag;
    assign rem  = a_neg ? (XLEN'(0) - r_mag) : r_mag;

    always_comb begin
        res_c = '0;
        if (is_div) begin
            res_c.hi = rem;
            res_c.lo = quot;
        end else begin
            res_c.hi = prod[PW-1:XLEN];
            res_c.lo = prod[XLEN-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit when the busy countdown expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  mdu_op_e         op_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    output logic            busy_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
    mdu_result_t            shadow_q, shadow_d;
    logic                   div0_q, div0_d;
    logic [XLEN-1:0]        hi_q, hi_d;
    logic [XLEN-1:0]        lo_q, lo_d;
    logic                   busy_q;
    mdu_result_t            res_c;

    mdu_compute u_compute (
        .a_i   (rs_data_i),
        .b_i   (rt_data_i),
        .op_i  (op_i),
        .res_c (res_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // New ops are only accepted from IDLE, so a completing op never overlaps an issue.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    unique case (op_i)
                        OP_MULT, OP_MULTU: begin
                            shadow_d = res_c;
                            div0_d   = 1'b0;
                            cnt_d    = MDU_CNT_W'(MULT_CYCLES);
                            state_d  = S_MUL_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            shadow_d = res_c;
                            div0_d   = (rt_data_i == '0);
                            cnt_d    = MDU_CNT_W'(DIV_CYCLES);
                            state_d  = S_DIV_RUN;
                        end
                        OP_MTHI: hi_d = rs_data_i;
                        OP_MTLO: lo_d = rs_data_i;
                        default: ;
                    endcase
                end
            end
            S_MUL_RUN, S_DIV_RUN: begin
                cnt_d = cnt_q - MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (!div0_q) begin
                        hi_d = shadow_q.hi;
                        lo_d = shadow_q.lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit with default latencies (MULT 5, DIV 10).
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    mdu_op_e     op;
    logic [31:0] rs, rt;
    logic        busy;
    logic [31:0] hi, lo;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start),
        .op_i      (op),
        .rs_data_i (rs),
        .rt_data_i (rt),
        .busy_o    (busy),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        mdu_op_e     op;
        logic [31:0] rs;
        logic [31:0] rt;
        int unsigned cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one op at a negedge, then count busy cycles and confirm HI/LO hold while busy.
    task automatic run_op(input string name, input mdu_op_e o, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hold_hi, hold_lo;
        int unsigned n;
        logic held;
        hold_hi = hi;
        hold_lo = lo;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'(cyc));
        if (cyc != 0) check({name, " hold"}, 32'(held), 32'd1);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    vec_t vecs[13];

    initial begin
        int unsigned n;
        reset = 1'b1; start = 1'b0; op = OP_NONE; rs = '0; rt = '0;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_MTHI,  32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h80000000};
        vecs[6]  = '{OP_MTLO,  32'h9ABCDEF0, 32'h00000000, 0,  32'h12345678, 32'h9ABCDEF0};
        vecs[7]  = '{OP_NONE,  32'h11111111, 32'h22222222, 0,  32'h12345678, 32'h9ABCDEF0};
        vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[9]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{OP_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14};
        vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'd3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'h0);

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].cyc, vecs[i].hi, vecs[i].lo);

        // MTLO issued while a multiply is in flight must be dropped.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        @(negedge clk);
        start = 1'b1; op = OP_MTLO; rs = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n = 2;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        check("mtlo_busy cycles", 32'(n), 32'd5);
        check("mtlo_busy hi", hi, 32'h0);
        check("mtlo_busy lo", lo, 32'd12);

        // Reset on the third busy cycle of a divide aborts it without commit.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1; op = OP_MULT; rs = 32'd9; rt = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op = OP_NONE;
        check("rst_div hi", hi, 32'h0);
        check("rst_div lo", lo, 32'h0);
        check("rst_div busy", 32'(busy), 32'h0);
        repeat (12) @(negedge clk);
        check("rst_div late lo", lo, 32'h0);
        run_op("post_rst mult", OP_MULT, 32'd6, 32'd7, 5, 32'h0, 32'd42);

        // Start on the final busy cycle is ignored; held one more cycle it is accepted.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; rs = 32'd2; rt = 32'd3;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        repeat (4) @(negedge clk);
        check("final busy", 32'(busy), 32'h1);
        start = 1'b1; op = OP_MULT; rs = 32'd10; rt = 32'd10;
        @(negedge clk);
        check("final ignored busy", 32'(busy), 32'h0);
        check("final ignored lo", lo, 32'd6);
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        check("reissue cycles", 32'(n), 32'd5);
        check("reissue lo", lo, 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set multiply busy duration in cycles (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set divide busy duration in cycles (legal 1..15).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  issue strobe; SHALL be qualified by op.
REQ-006 op  input  3  operation code from the shared package: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 rs_data  input  32  forwarded rs operand from the E stage (GRF read data after bypass).
REQ-008 rt_data  input  32  forwarded rt operand from the E stage.
REQ-009 busy  output  1  high while a multiply or divide is in flight.
REQ-010 hi  output  32  architectural HI register, read by mfhi.
REQ-011 lo  output  32  architectural LO register, read by mflo.

Function
REQ-012 The unit SHALL be a three-state FSM: IDLE, MUL_RUN, DIV_RUN.
REQ-013 In IDLE, when start=1 and op is MULT/MULTU, the unit SHALL latch the 64-bit product in a shadow register, load the counter with MULT_CYCLES, and enter MUL_RUN.
REQ-014 In IDLE, when start=1 and op is DIV/DIVU, the unit SHALL latch the quotient and remainder in shadow registers, load the counter with DIV_CYCLES, and enter DIV_RUN.
REQ-015 busy SHALL be 1 exactly while the state is not IDLE; busy is therefore high for N consecutive cycles starting the cycle after start.
REQ-016 In a RUN state the counter SHALL decrement each cycle; at the edge where it reaches 0, hi/lo SHALL take the shadow values and the state SHALL return to IDLE in the same edge.
REQ-017 hi/lo SHALL remain unchanged during RUN; mfhi/mflo stalling on start|busy is the hazard unit's job.
REQ-018 MULT SHALL form a signed 32x32->64 product; MULTU SHALL form an unsigned product; hi=product[63:32], lo=product[31:0].
REQ-019 DIV/DIVU SHALL write lo=quotient and hi=remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Divide by zero (rt_data=0) SHALL still hold busy for DIV_CYCLES and SHALL leave hi/lo unchanged at completion.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no trap.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write rs_data into hi/lo at the next edge, with busy staying 0.
REQ-023 Any start while busy=1 SHALL be ignored: no state, counter, shadow, hi, or lo change.
REQ-024 start with op=NONE SHALL be a no-op.
REQ-025 A completing operation SHALL NOT accept a new start in the same cycle; a new op is accepted only from IDLE.

Reset
REQ-026 While reset=1 at an edge, hi=0, lo=0, the state SHALL be IDLE, the counter 0, the shadows 0, and busy=0.
REQ-027 Reset mid-operation SHALL abort the operation with no hi/lo commit; reset SHALL dominate start.

Structure
REQ-028 The op encoding and the default cycle counts SHALL live in the shared CPU package used by the controller and hazard unit.
REQ-029 One sub-module is natural: mdu_compute (combinational product/quotient/remainder with signed/unsigned select); the FSM, counter, and registers stay in mult_div_unit.

Verification
REQ-030 MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-032 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-033 MTHI 0x12345678 from IDLE -> hi=0x12345678 at the next edge, busy stays 0; MTLO issued during busy -> ignored.
REQ-034 Reset asserted at busy cycle 3 of a DIV -> hi=lo=0, busy=0, state IDLE; the next MULT runs normally.
REQ-035 A second MULT start on the final busy cycle is ignored; re-issued the cycle after busy falls, it is accepted.
